division_unit: RTL and testbench
================================

// Module: division_unit
// PURPOSE
//  Multi-cycle restoring divider for the MIPS datapath: DIV/DIVU, the inverse of the shift-add multiplier.
//  Writes quotient to LO and remainder to HI, for MFHI/MFLO.
//  The control FSM pulses start and stalls on busy until done.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; must be >= 2
// PORTS
//  clock     in   1      clock; all state updates on rising edge
//  reset     in   1      asynchronous, active-high
//  start     in   1      request a divide; sampled only in IDLE
//  is_signed in   1      1 = DIV (two's complement), 0 = DIVU; latched with start
//  A         in   WIDTH  dividend; latched with start
//  B         in   WIDTH  divisor; latched with start
//  HI        out  WIDTH  remainder of last completed divide
//  LO        out  WIDTH  quotient of last completed divide
//  busy      out  1      high from cycle after start accepted until DONE exits
//  done      out  1      one-cycle pulse; HI/LO/div_zero valid and stable from this cycle
//  div_zero  out  1      last completed divide had B == 0
// BEHAVIOUR
//  Reset: state=IDLE; HI, LO, busy, done, div_zero = 0; internal regs cleared.
//  Reset mid-operation aborts immediately. No result is written. The next start is accepted normally.
//  States: IDLE -> CALC (WIDTH cycles) -> FIX (1) -> DONE (1) -> IDLE.
//   IDLE: if start, latch is_signed, |A|, |B|, sign_q = signed & (A[msb]^B[msb]), sign_r = signed & A[msb].
//         If B==0, go to FIX with dz flag set; else clear rem (WIDTH+1 b), quot=|A|, cnt=0, go to CALC.
//   CALC: rs = {rem[WIDTH-1:0], quot[msb]}; d = rs - {1'b0,|B|}.
//         If d >= 0: rem=d, quot={quot<<1 | 1}; else rem=rs, quot=quot<<1.
//         cnt++; leave to FIX after the WIDTH-th step.
//   FIX:  LO = sign_q ? -quot : quot; HI = sign_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0].
//         div_zero <= dz. If dz: LO = {WIDTH{1'b1}}, HI = A as latched (raw, unsigned).
//   DONE: done=1 for exactly this cycle; return to IDLE.
//  Latency: start sampled at edge 0 -> done high in cycle WIDTH+2 (34 for WIDTH=32). For B==0: cycle 2.
//  HI/LO change only on the FIX->DONE edge; otherwise they hold the previous result.
//  Magnitude: |x| = x[msb] ? -x : x, only when is_signed; unsigned ops use raw bits.
//  Signed overflow (-2^(W-1) / -1): LO = 2^(W-1) bit pattern (wraps), HI = 0. Not flagged.
//  Remainder sign follows dividend; quotient truncates toward zero (MIPS semantics).
//  start while busy (CALC/FIX/DONE): ignored, not queued. A/B/is_signed changes mid-op are ignored.
//  busy = (state != IDLE); done = (state == DONE); both combinational from the state register.
//  cnt width = $clog2(WIDTH)+1; no arithmetic wider than WIDTH+1 bits.
// STRUCTURE
//  Shared package mips_muldiv_pkg:
//   - enum div_state_t {IDLE, CALC, FIX, DONE} (logic [1:0]).
//   - localparam DIV_ZERO_QUOT = all-ones.
//   - The multiplier reuses the same package for its own state enum.
//  One sub-module, div_step: combinational single restoring step. (rem, quot, divisor) -> (rem_n, quot_n).
//  Kept separate so it can be unit-tested exhaustively at WIDTH=4.
//  FSM, sign handling and output registers stay in division_unit.
// TESTING
//  1 DIVU A=100, B=7 -> cycle 34: done=1, LO=14, HI=2, div_zero=0; busy high cycles 1..34.
//  2 DIV A=-7 (0xFFFFFFF9), B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
//  3 DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU same operands -> LO=0, HI=0x80000000.
//  4 DIVU A=5, B=0 -> cycle 2: done=1, div_zero=1, LO=0xFFFFFFFF, HI=5. Next valid divide clears div_zero.
//  5 DIVU 0xFFFFFFFF/1, pulse start again at cycle 10 with A=9,B=3 -> second start ignored.
//    Result at cycle 34 is LO=0xFFFFFFFF, HI=0.
//  6 Assert reset at cycle 15 of a divide -> HI=LO=0, busy=0, no done pulse.
//    A fresh 20/6 then yields LO=3, HI=2.

Source files
------------

// File: rtl/mips_muldiv_pkg.sv
// Shared types and constants for the MIPS multiply/divide units.
// Imported by the divider and the shift-add multiplier.
package mips_muldiv_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } div_state_t;

   typedef enum logic [1:0] {
      MUL_IDLE,
      MUL_CALC,
      MUL_DONE
   } mul_state_t;

   // Widest datapath either unit is built for.
   localparam int MULDIV_MAX_WIDTH = 64;

   localparam logic [MULDIV_MAX_WIDTH-1:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/division_unit_if.sv
// Request/result bundle between the control FSM and the divider.
// The master issues divides; the slave is the divider itself.
interface division_unit_if #(
   parameter int WIDTH = 32
);

   logic             start;
   logic             is_signed;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [WIDTH-1:0] HI;
   logic [WIDTH-1:0] LO;
   logic             busy;
   logic             done;
   logic             div_zero;

   modport master (
      output start, is_signed, A, B,
      input  HI, LO, busy, done, div_zero
   );

   modport slave (
      input  start, is_signed, A, B,
      output HI, LO, busy, done, div_zero
   );

endinterface

// File: rtl/division_unit_div_step.sv
// One combinational restoring-division step.
// Shifts the next dividend bit into the remainder and trial-subtracts.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   rem_i,
   input  logic [WIDTH-1:0] quot_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH:0]   rem_o,
   output logic [WIDTH-1:0] quot_o
);

   logic [WIDTH:0] rs;
   logic [WIDTH:0] dv;
   logic           ge;

   assign rs = {rem_i[WIDTH-1:0], quot_i[WIDTH-1]};
   assign dv = {1'b0, divisor_i};

   // rem stays below the divisor, so its top bit only ever forces a subtract.
   assign ge = rem_i[WIDTH] | (rs >= dv);

   assign rem_o  = ge ? (rs - dv) : rs;
   assign quot_o = {quot_i[WIDTH-2:0], ge};

endmodule

// File: rtl/division_unit.sv
// Multi-cycle restoring divider for DIV/DIVU.
// Quotient goes to LO, remainder to HI, on the FIX->DONE edge.
module division_unit
   import mips_muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input logic            clock,
   input logic            reset,
   division_unit_if.slave bus
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   div_state_t state_q, state_d;

   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]   rem_q, rem_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic             sq_q, sq_d;
   logic             sr_q, sr_d;
   logic             dz_q, dz_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             dzo_q, dzo_d;

   logic [WIDTH:0]   rem_n;
   logic [WIDTH-1:0] quot_n;
   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;
   logic             neg_a;
   logic             neg_b;

   div_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .rem_i    (rem_q),
      .quot_i   (quot_q),
      .divisor_i(dvs_q),
      .rem_o    (rem_n),
      .quot_o   (quot_n)
   );

   assign neg_a = bus.is_signed & bus.A[WIDTH-1];
   assign neg_b = bus.is_signed & bus.B[WIDTH-1];
   assign abs_a = neg_a ? -bus.A : bus.A;
   assign abs_b = neg_b ? -bus.B : bus.B;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quot_d  = quot_q;
      dvs_d   = dvs_q;
      a_d     = a_q;
      sq_d    = sq_q;
      sr_d    = sr_q;
      dz_d    = dz_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dzo_d   = dzo_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_d    = bus.A;
               dvs_d  = abs_b;
               sq_d   = neg_a ^ neg_b;
               sr_d   = neg_a;
               dz_d   = (bus.B == '0);
               rem_d  = '0;
               quot_d = abs_a;
               cnt_d  = '0;
               state_d = (bus.B == '0) ? FIX : CALC;
            end
         end
         CALC: begin
            rem_d  = rem_n;
            quot_d = quot_n;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d = FIX;
            end
         end
         FIX: begin
            dzo_d = dz_q;
            if (dz_q) begin
               lo_d = DIV_ZERO_QUOT[WIDTH-1:0];
               hi_d = a_q;
            end else begin
               lo_d = sq_q ? -quot_q : quot_q;
               hi_d = sr_q ? -rem_q[WIDTH-1:0]
                           : rem_q[WIDTH-1:0];
            end
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quot_q  <= '0;
         dvs_q   <= '0;
         a_q     <= '0;
         sq_q    <= 1'b0;
         sr_q    <= 1'b0;
         dz_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         dzo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quot_q  <= quot_d;
         dvs_q   <= dvs_d;
         a_q     <= a_d;
         sq_q    <= sq_d;
         sr_q    <= sr_d;
         dz_q    <= dz_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         dzo_q   <= dzo_d;
      end
   end

   assign bus.HI       = hi_q;
   assign bus.LO       = lo_q;
   assign bus.div_zero = dzo_q;
   assign bus.busy     = (state_q != IDLE);
   assign bus.done     = (state_q == DONE);

endmodule

// File: tb/tb_division_unit.sv
// Bench for division_unit: directed MIPS cases, ignored restart,
// mid-op reset and random operands against an arithmetic model.
module tb_division_unit;

   localparam int W = 32;

   logic clock = 1'b0;
   logic reset;

   division_unit_if #(.WIDTH(W)) bus ();

   division_unit #(.WIDTH(W)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   // Result the DUT should currently be holding.
   logic [W-1:0] last_lo = '0;
   logic [W-1:0] last_hi = '0;
   logic         last_dz = 1'b0;

   function automatic void ref_div(
      input  bit           s,
      input  logic [W-1:0] a,
      input  logic [W-1:0] b,
      output logic [W-1:0] q,
      output logic [W-1:0] r,
      output logic         z
   );
      int sa;
      int sb;
      sa = a;
      sb = b;
      z = (b == 0);
      if (z) begin
         q = '1;
         r = a;
      end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = a;
         r = '0;
      end else if (s) begin
         q = sa / sb;
         r = sa % sb;
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   // Issues one divide and observes it; optionally pulses start again mid-op.
   task automatic run_div(
      input  bit           s,
      input  logic [W-1:0] a,
      input  logic [W-1:0] b,
      input  int           inject_cyc,
      output int           lat,
      output int           busy_cnt,
      output bit           held_ok,
      output bit           pulse_ok,
      output logic [W-1:0] lo,
      output logic [W-1:0] hi,
      output logic         dz
   );
      @(negedge clock);
      bus.start     = 1'b1;
      bus.is_signed = s;
      bus.A         = a;
      bus.B         = b;
      @(posedge clock);
      #1;
      bus.start     = 1'b0;
      bus.A         = $urandom;
      bus.B         = $urandom;
      bus.is_signed = 1'($urandom_range(0, 1));
      lat      = -1;
      busy_cnt = 0;
      held_ok  = 1'b1;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clock);
         if (bus.busy) busy_cnt++;
         if (bus.done) begin
            lat = c;
            break;
         end
         if (bus.LO !== last_lo || bus.HI !== last_hi ||
             bus.div_zero !== last_dz) held_ok = 1'b0;
         if (c == inject_cyc) begin
            bus.start     = 1'b1;
            bus.is_signed = 1'b0;
            bus.A         = 32'd9;
            bus.B         = 32'd3;
            @(posedge clock);
            #1;
            bus.start = 1'b0;
         end
      end
      lo = bus.LO;
      hi = bus.HI;
      dz = bus.div_zero;
      @(negedge clock);
      pulse_ok = !bus.done && !bus.busy && bus.LO === lo && bus.HI === hi;
   endtask

   task automatic test_reset();
      reset         = 1'b1;
      bus.start     = 1'b0;
      bus.is_signed = 1'b0;
      bus.A         = '0;
      bus.B         = '0;
      repeat (3) @(negedge clock);
      n_checks++;
      if (bus.HI !== '0 || bus.LO !== '0) begin
         n_fail++;
         $display("FAIL reset_hilo: HI=%h LO=%h want 0/0", bus.HI, bus.LO);
      end
      n_checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_zero !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags: busy=%b done=%b dz=%b want 000",
                  bus.busy, bus.done, bus.div_zero);
      end
      reset = 1'b0;
      repeat (2) @(negedge clock);
      n_checks++;
      if (bus.busy !== 1'b0 || bus.LO !== '0) begin
         n_fail++;
         $display("FAIL reset_idle: busy=%b LO=%h want 0/0", bus.busy, bus.LO);
      end
   endtask

   typedef struct {
      bit           s;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] lo;
      logic [W-1:0] hi;
      logic         dz;
   } vec_t;

   task automatic test_directed();
      vec_t v[6];
      int lat, bc;
      bit hok, pok;
      logic [W-1:0] lo, hi;
      logic dz;
      int want_lat;
      v[0] = '{1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
      v[1] = '{1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
      v[2] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0};
      v[3] = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0};
      v[4] = '{1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1};
      v[5] = '{1'b1, 32'd20, 32'hFFFF_FFFA, 32'hFFFF_FFFD, 32'd2, 1'b0};
      foreach (v[i]) begin
         run_div(v[i].s, v[i].a, v[i].b, 0, lat, bc, hok, pok, lo, hi, dz);
         want_lat = v[i].dz ? 2 : W + 2;
         n_checks++;
         if (lat != want_lat) begin
            n_fail++;
            $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, want_lat);
         end
         n_checks++;
         if (lo !== v[i].lo || hi !== v[i].hi || dz !== v[i].dz) begin
            n_fail++;
            $display("FAIL dir%0d_result: LO=%h HI=%h dz=%b want %h %h %b",
                     i, lo, hi, dz, v[i].lo, v[i].hi, v[i].dz);
         end
         n_checks++;
         if (bc != want_lat || !hok || !pok) begin
            n_fail++;
            $display("FAIL dir%0d_handshake: busy_cycles=%0d held=%b pulse=%b want %0d 1 1",
                     i, bc, hok, pok, want_lat);
         end
         last_lo = v[i].lo;
         last_hi = v[i].hi;
         last_dz = v[i].dz;
      end
   endtask

   task automatic test_ignore_start();
      int lat, bc;
      bit hok, pok;
      logic [W-1:0] lo, hi;
      logic dz;
      run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 10, lat, bc, hok, pok, lo, hi, dz);
      n_checks++;
      if (lat != W + 2 || lo !== 32'hFFFF_FFFF || hi !== 32'd0 || dz !== 1'b0) begin
         n_fail++;
         $display("FAIL ignore_start: lat=%0d LO=%h HI=%h dz=%b want %0d ffffffff 0 0",
                  lat, lo, hi, dz, W + 2);
      end
      n_checks++;
      if (!pok) begin
         n_fail++;
         $display("FAIL ignore_start_idle: pulse/idle check got 0 want 1");
      end
      last_lo = 32'hFFFF_FFFF;
      last_hi = 32'd0;
      last_dz = 1'b0;
   endtask

   task automatic test_reset_mid();
      int lat, bc, n_done;
      bit hok, pok;
      logic [W-1:0] lo, hi;
      logic dz;
      @(negedge clock);
      bus.start     = 1'b1;
      bus.is_signed = 1'b0;
      bus.A         = 32'd1000;
      bus.B         = 32'd3;
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      repeat (15) @(negedge clock);
      reset = 1'b1;
      #1;
      n_checks++;
      if (bus.HI !== '0 || bus.LO !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid: HI=%h LO=%h busy=%b done=%b want 0 0 0 0",
                  bus.HI, bus.LO, bus.busy, bus.done);
      end
      @(negedge clock);
      reset = 1'b0;
      n_done = 0;
      repeat (40) begin
         @(negedge clock);
         if (bus.done || bus.busy) n_done++;
      end
      n_checks++;
      if (n_done != 0) begin
         n_fail++;
         $display("FAIL reset_mid_quiet: busy/done cycles=%0d want 0", n_done);
      end
      last_lo = '0;
      last_hi = '0;
      last_dz = 1'b0;
      run_div(1'b0, 32'd20, 32'd6, 0, lat, bc, hok, pok, lo, hi, dz);
      n_checks++;
      if (lat != W + 2 || lo !== 32'd3 || hi !== 32'd2 || !hok) begin
         n_fail++;
         $display("FAIL reset_mid_fresh: lat=%0d LO=%h HI=%h held=%b want %0d 3 2 1",
                  lat, lo, hi, hok, W + 2);
      end
      last_lo = 32'd3;
      last_hi = 32'd2;
   endtask

   task automatic test_random();
      int lat, bc;
      bit hok, pok;
      logic [W-1:0] lo, hi, a, b, elo, ehi;
      logic dz, edz;
      bit s;
      for (int i = 0; i < 40; i++) begin
         s = 1'($urandom_range(0, 1));
         a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
         case ($urandom_range(0, 4))
            0: b = $urandom;
            1: b = $urandom_range(1, 15);
            2: b = '0;
            3: b = 32'hFFFF_FFFF;
            default: b = $urandom >> $urandom_range(0, 31);
         endcase
         ref_div(s, a, b, elo, ehi, edz);
         run_div(s, a, b, 0, lat, bc, hok, pok, lo, hi, dz);
         n_checks++;
         if (lo !== elo || hi !== ehi || dz !== edz ||
             lat != (edz ? 2 : W + 2) || !hok || !pok) begin
            n_fail++;
            $display("FAIL rand%0d s=%b a=%h b=%h: LO=%h HI=%h dz=%b lat=%0d want %h %h %b %0d",
                     i, s, a, b, lo, hi, dz, lat, elo, ehi, edz, edz ? 2 : W + 2);
         end
         last_lo = elo;
         last_hi = ehi;
         last_dz = edz;
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_ignore_start();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
